sbase_pulse_meter: RTL



---
 rtl/sbase_timer_pkg.sv | 15 +
 rtl/sbase_pulse_meter_if.sv | 25 ++
 rtl/sbase_sync_edge.sv | 35 +++
 rtl/sbase_pulse_meter.sv | 89 ++++++++
 4 files changed

// File: rtl/sbase_timer_pkg.sv
// Shared definitions for the sbase timer family (one-shot timer and pulse meter).
//   state_t  : measurement/timing state machine states
//   SBASE_BW : default counter width shared across the family
package sbase_timer_pkg;

  localparam int unsigned SBASE_BW = 24;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOW,
    WAIT_RISE,
    MEASURE
  } state_t;

endpackage

// File: rtl/sbase_pulse_meter_if.sv
// Pulse meter signal bundle.
//   PIN   : asynchronous pulse input to measure
//   ARM   : one-cycle arm/re-arm strobe
//   MODE  : 0 = single-shot, 1 = continuous
//   WIDTH : last captured high width in clock cycles
//   VALID : one-cycle strobe, WIDTH/OVF updated
//   OVF   : last capture saturated
//   BUSY  : meter is not idle
// master drives PIN/ARM/MODE; slave is the meter.
interface sbase_pulse_meter_if import sbase_timer_pkg::*; #(
  parameter int unsigned BW = SBASE_BW
) ();

  logic          PIN;
  logic          ARM;
  logic          MODE;
  logic [BW-1:0] WIDTH;
  logic          VALID;
  logic          OVF;
  logic          BUSY;

  modport master (output PIN, ARM, MODE, input WIDTH, VALID, OVF, BUSY);
  modport slave  (input PIN, ARM, MODE, output WIDTH, VALID, OVF, BUSY);

endinterface

// File: rtl/sbase_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a delay flop for
// rising-edge detection.
//   CLK   : system clock
//   R     : asynchronous active-high reset
//   PIN   : asynchronous input
//   pin_s : synchronized input (2 cycles after PIN)
//   rise  : pin_s high this cycle and low the cycle before
module sbase_sync_edge (
  input  logic CLK,
  input  logic R,
  input  logic PIN,
  output logic pin_s,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= PIN;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign pin_s = sync;
  assign rise  = sync & ~sync_d;

endmodule

// File: rtl/sbase_pulse_meter.sv
// Pulse width meter: measures the high width of PIN in CLK cycles.
// Single-shot mode captures one pulse per ARM; continuous mode keeps
// capturing every pulse after the first ARM.
//   CLK : system clock
//   R   : asynchronous active-high reset
//   bus : slave side of sbase_pulse_meter_if (PIN/ARM/MODE in,
//         WIDTH/VALID/OVF/BUSY out)
module sbase_pulse_meter import sbase_timer_pkg::*; #(
  parameter int unsigned BW = SBASE_BW
) (
  input logic                 CLK,
  input logic                 R,
  sbase_pulse_meter_if.slave  bus
);

  localparam logic [BW-1:0] CNT_MAX = '1;
  localparam logic [BW-1:0] CNT_ONE = BW'(1);

  logic          pin_s;
  logic          rise;
  state_t        state;
  logic [BW-1:0] count;
  logic [BW-1:0] width;
  logic          valid;
  logic          ovf;
  logic          busy;

  sbase_sync_edge u_sync (
    .CLK   (CLK),
    .R     (R),
    .PIN   (bus.PIN),
    .pin_s (pin_s),
    .rise  (rise)
  );

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state <= IDLE;
      count <= '0;
      width <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= 1'b0;
      // ARM overrides everything, including a capture in the same cycle.
      if (bus.ARM) begin
        state <= WAIT_LOW;
        count <= '0;
        busy  <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          WAIT_LOW: begin
            if (!pin_s) state <= WAIT_RISE;
          end
          WAIT_RISE: begin
            if (rise) begin
              state <= MEASURE;
              count <= CNT_ONE;
            end
          end
          MEASURE: begin
            if (pin_s) begin
              if (count != CNT_MAX) count <= count + CNT_ONE;
            end else begin
              width <= count;
              ovf   <= (count == CNT_MAX);
              valid <= 1'b1;
              if (bus.MODE) begin
                state <= WAIT_RISE;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.WIDTH = width;
  assign bus.VALID = valid;
  assign bus.OVF   = ovf;
  assign bus.BUSY  = busy;

endmodule
